// File: rtl/sd_pkg.sv
// Shared SD command definitions: frame geometry, CRC7 polynomial, command
// indices, sender state encoding and the serial CRC7 step.
package sd_pkg;

  localparam int CMD_FRAME_LEN = 48;
  localparam int CRC_MSG_BITS  = 40;
  localparam int CRC_BITS      = 7;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_TRAIL_ENC = 2'd2;
  localparam logic [1:0] ST_WAIT_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_TRAIL = ST_TRAIL_ENC,
    ST_WAIT  = ST_WAIT_ENC
  } sd_state_t;

  // One message bit into a Galois-style CRC7 register (x^7 + x^3 + 1).
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator: clr restarts at zero, en folds in one bit.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] r_crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= 7'h00;
    end else if (clr) begin
      r_crc <= 7'h00;
    end else if (en) begin
      r_crc <= crc7_step(r_crc, din);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/sd_cmd_sender.sv
// SPI-mode SD command sender: serialises a 48-bit command frame with CRC7,
// clocks trail bits, then holds resp_en while waiting for the response block.
module sd_cmd_sender
  import sd_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int TRAIL_BITS   = 8,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_done,
  output logic        busy,
  output logic        done,
  output logic        resp_en,
  output logic        timeout,
  output logic        sd_cs_n,
  output logic        sd_sclk,
  output logic        sd_mosi
);

  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam int TRAIL_W = $clog2(TRAIL_BITS + 1);
  localparam int TO_W    = $clog2(RESP_TIMEOUT + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [TRAIL_W-1:0] TRAIL_LAST = TRAIL_W'(TRAIL_BITS - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(RESP_TIMEOUT - 1);
  localparam logic [5:0]         FIRST_BIT  = 6'(CMD_FRAME_LEN - 1);
  localparam logic [5:0]         CRC_START  = 6'(CMD_FRAME_LEN - CRC_MSG_BITS);

  sd_state_t            r_state;
  logic [DIV_W-1:0]     r_div;
  logic                 r_sclk;
  logic                 r_mosi;
  logic                 r_cs_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_resp_en;
  logic                 r_timeout;
  logic [5:0]           r_bit_cnt;
  logic [TRAIL_W-1:0]   r_trail_cnt;
  logic [TO_W-1:0]      r_wait_cnt;
  logic [CRC_MSG_BITS-1:0] r_msg;

  logic       w_half_end;
  logic       w_bit_end;
  logic       w_accept;
  logic       w_crc_en;
  logic [6:0] w_crc;
  logic [5:0] w_next_idx;
  logic [5:0] w_msg_idx;
  logic [2:0] w_crc_idx;
  logic       w_next_bit;

  assign w_half_end = (r_div == DIV_LAST);
  assign w_bit_end  = w_half_end && r_sclk;
  assign w_accept   = (r_state == ST_IDLE) && start;

  // Fold each message bit into the CRC in the first cycle of its bit period,
  // so the final CRC is settled well before the first CRC bit is launched.
  assign w_crc_en = (r_state == ST_SHIFT) && !r_sclk && (r_div == '0) &&
                    (r_bit_cnt >= CRC_START);

  sd_crc7 u_crc7 (
    .clk (clk),
    .rst (rst),
    .clr (w_accept),
    .en  (w_crc_en),
    .din (r_mosi),
    .crc (w_crc)
  );

  // Frame bit position n: n>=8 message, 7..1 CRC (MSB first), 0 end bit.
  always_comb begin
    w_next_idx = r_bit_cnt - 6'd1;
    w_msg_idx  = w_next_idx - CRC_START;
    w_crc_idx  = 3'(w_next_idx - 6'd1);
    w_next_bit = 1'b1;
    if (w_next_idx >= CRC_START) begin
      w_next_bit = r_msg[w_msg_idx];
    end else if (w_next_idx != 6'd0) begin
      w_next_bit = w_crc[w_crc_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b1;
      r_cs_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_resp_en   <= 1'b0;
      r_timeout   <= 1'b0;
      r_bit_cnt   <= '0;
      r_trail_cnt <= '0;
      r_wait_cnt  <= '0;
      r_msg       <= '0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;

      if (r_state != ST_IDLE) begin
        if (w_half_end) begin
          r_div  <= '0;
          r_sclk <= ~r_sclk;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          r_div     <= '0;
          r_sclk    <= 1'b0;
          r_mosi    <= 1'b1;
          r_cs_n    <= 1'b1;
          r_busy    <= 1'b0;
          r_resp_en <= 1'b0;
          if (start) begin
            r_msg     <= {2'b01, cmd_index, cmd_arg};
            r_state   <= ST_SHIFT;
            r_bit_cnt <= FIRST_BIT;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b0;
            r_busy    <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (w_bit_end) begin
            if (r_bit_cnt == 6'd0) begin
              r_state     <= ST_TRAIL;
              r_trail_cnt <= TRAIL_LAST;
              r_mosi      <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt - 6'd1;
              r_mosi    <= w_next_bit;
            end
          end
        end

        ST_TRAIL: begin
          r_mosi <= 1'b1;
          if (w_bit_end) begin
            if (r_trail_cnt == '0) begin
              r_done     <= 1'b1;
              r_state    <= ST_WAIT;
              r_wait_cnt <= '0;
            end else begin
              r_trail_cnt <= r_trail_cnt - 1'b1;
            end
          end
        end

        ST_WAIT: begin
          r_mosi    <= 1'b1;
          r_resp_en <= 1'b1;
          // A response completing on the timeout cycle suppresses the timeout.
          if (resp_done || (w_bit_end && (r_wait_cnt == TO_LAST))) begin
            r_timeout <= ~resp_done;
            r_state   <= ST_IDLE;
            r_resp_en <= 1'b0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_div     <= '0;
            r_busy    <= 1'b0;
          end else if (w_bit_end) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign resp_en = r_resp_en;
  assign timeout = r_timeout;
  assign sd_cs_n = r_cs_n;
  assign sd_sclk = r_sclk;
  assign sd_mosi = r_mosi;

endmodule

// File: tb/tb_sd_cmd_sender.sv
// Self-checking bench for sd_cmd_sender: frames captured on SCLK rising edges
// are compared with a polynomial-division CRC7 reference model.
module tb_sd_cmd_sender;
  import sd_pkg::*;

  localparam int CLK_DIV      = 2;
  localparam int TRAIL_BITS   = 8;
  localparam int RESP_TIMEOUT = 64;
  localparam int BITP         = 2 * CLK_DIV;
  localparam int DONE_LAT     = (48 + TRAIL_BITS) * BITP;
  localparam int TO_LAT       = RESP_TIMEOUT * BITP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        resp_done = 1'b0;
  logic        busy, done, resp_en, timeout, sd_cs_n, sd_sclk, sd_mosi;

  int total = 0;
  int bad = 0;
  int timeout_seen = 0;

  sd_cmd_sender #(
    .CLK_DIV      (CLK_DIV),
    .TRAIL_BITS   (TRAIL_BITS),
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .resp_done (resp_done),
    .busy      (busy),
    .done      (done),
    .resp_en   (resp_en),
    .timeout   (timeout),
    .sd_cs_n   (sd_cs_n),
    .sd_sclk   (sd_sclk),
    .sd_mosi   (sd_mosi)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (timeout === 1'b1) timeout_seen++;

  // Reference: frame = {01, index, arg, crc7, 1}; crc7 = remainder of msg*x^7 / 0x89.
  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    logic [46:0] r;
    msg = {2'b01, idx, arg};
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return {msg, r[6:0], 1'b1};
  endfunction

  // Starts a command and records what appears on the SPI pins until done.
  // k counts cycles from the first SHIFT cycle (k=0).
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg,
                           input int inject_k, input int stop_bits,
                           output logic [47:0] bits, output int nbits,
                           output int done_k, output logic [2:0] first_obs,
                           output int cs_bad, output int per_bad, output int trail_bad);
    logic prev;
    int last_rise;
    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cmd_index = 6'($urandom); cmd_arg = $urandom;
    bits = '0; nbits = 0; done_k = -1; cs_bad = 0; per_bad = 0; trail_bad = 0;
    prev = 1'b0; last_rise = -1;
    first_obs = {sd_cs_n, busy, sd_mosi};
    for (int k = 0; k < DONE_LAT + 50; k++) begin
      if (k > 0) @(negedge clk);
      start = 1'b0; resp_done = 1'b0;
      if (done === 1'b1) begin done_k = k; break; end
      if (sd_cs_n !== 1'b0) cs_bad++;
      if (prev === 1'b0 && sd_sclk === 1'b1) begin
        if (last_rise >= 0 && (k - last_rise) != BITP) per_bad++;
        last_rise = k;
        if (nbits < 48) bits = {bits[46:0], sd_mosi};
        else if (sd_mosi !== 1'b1) trail_bad++;
        nbits++;
        if (stop_bits > 0 && nbits == stop_bits) break;
      end
      prev = sd_sclk;
      if (k == inject_k) begin
        start = 1'b1; cmd_index = CMD17; resp_done = 1'b1;
      end
    end
    start = 1'b0; resp_done = 1'b0;
    $display("frame idx=%0d arg=%08h bits=%012h nbits=%0d done_k=%0d", idx, arg, bits, nbits, done_k);
  endtask

  task automatic end_resp(input int delay);
    repeat (delay) @(negedge clk);
    resp_done = 1'b1;
    @(negedge clk);
    resp_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (resp_en !== 1'b0) begin bad++; $display("FAIL reset_resp_en: got %b expected 0", resp_en); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    total++; if (sd_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b expected 1", sd_cs_n); end
    total++; if (sd_sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b expected 0", sd_sclk); end
    total++; if (sd_mosi !== 1'b1) begin bad++; $display("FAIL reset_mosi: got %b expected 1", sd_mosi); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_cmd0;
    logic [47:0] bits; logic [2:0] fo; int nb, dk, csb, pb, tb;
    run_frame(CMD0, 32'h0, -1, 0, bits, nb, dk, fo, csb, pb, tb);
    total++; if (fo !== 3'b010) begin bad++; $display("FAIL cmd0_first_cycle: got cs/busy/mosi=%b expected 010", fo); end
    total++; if (bits !== 48'h400000000095) begin bad++; $display("FAIL cmd0_frame: got %012h expected 400000000095", bits); end
    total++; if (dk != DONE_LAT) begin bad++; $display("FAIL cmd0_done_latency: got %0d expected %0d", dk, DONE_LAT); end
    total++; if (nb != 48 + TRAIL_BITS) begin bad++; $display("FAIL cmd0_bit_count: got %0d expected %0d", nb, 48 + TRAIL_BITS); end
    total++; if (tb != 0) begin bad++; $display("FAIL cmd0_trail_bits: got %0d zero bits expected 0", tb); end
    total++; if (resp_en !== 1'b0) begin bad++; $display("FAIL cmd0_resp_en_with_done: got %b expected 0", resp_en); end
    @(negedge clk);
    total++; if (resp_en !== 1'b1) begin bad++; $display("FAIL cmd0_resp_en_rise: got %b expected 1", resp_en); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL cmd0_done_one_cycle: got %b expected 0", done); end
    end_resp(5);
  endtask

  task automatic test_cmd8;
    logic [47:0] bits; logic [2:0] fo; int nb, dk, csb, pb, tb;
    run_frame(CMD8, 32'h000001AA, -1, 0, bits, nb, dk, fo, csb, pb, tb);
    total++; if (bits !== 48'h48000001AA87) begin bad++; $display("FAIL cmd8_frame: got %012h expected 48000001aa87", bits); end
    total++; if (csb != 0) begin bad++; $display("FAIL cmd8_cs_low: got %0d high cycles expected 0", csb); end
    total++; if (pb != 0) begin bad++; $display("FAIL cmd8_sclk_period: got %0d bad periods expected 0", pb); end
    end_resp(3);
  endtask

  task automatic test_random;
    logic [47:0] bits; logic [2:0] fo; int nb, dk, csb, pb, tb;
    logic [5:0] idx; logic [31:0] arg;
    for (int n = 0; n < 4; n++) begin
      idx = 6'($urandom_range(0, 63));
      arg = $urandom;
      run_frame(idx, arg, -1, 0, bits, nb, dk, fo, csb, pb, tb);
      total++; if (bits !== ref_frame(idx, arg)) begin bad++; $display("FAIL random_frame: got %012h expected %012h", bits, ref_frame(idx, arg)); end
      total++; if (dk != DONE_LAT) begin bad++; $display("FAIL random_done_latency: got %0d expected %0d", dk, DONE_LAT); end
      end_resp(int'($urandom_range(1, 30)));
    end
  endtask

  task automatic test_resp_done;
    logic [47:0] bits; logic [2:0] fo; int nb, dk, csb, pb, tb, to0;
    to0 = timeout_seen;
    run_frame(CMD55, 32'h0, -1, 0, bits, nb, dk, fo, csb, pb, tb);
    total++; if (bits !== ref_frame(CMD55, 32'h0)) begin bad++; $display("FAIL cmd55_frame: got %012h expected %012h", bits, ref_frame(CMD55, 32'h0)); end
    repeat (20) @(negedge clk);
    total++; if (resp_en !== 1'b1) begin bad++; $display("FAIL wait_resp_en: got %b expected 1", resp_en); end
    resp_done = 1'b1;
    @(negedge clk);
    resp_done = 1'b0;
    total++; if (resp_en !== 1'b0) begin bad++; $display("FAIL resp_done_resp_en: got %b expected 0", resp_en); end
    total++; if (sd_cs_n !== 1'b1) begin bad++; $display("FAIL resp_done_cs_n: got %b expected 1", sd_cs_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL resp_done_busy: got %b expected 0", busy); end
    total++; if (sd_sclk !== 1'b0) begin bad++; $display("FAIL resp_done_sclk: got %b expected 0", sd_sclk); end
    repeat (TO_LAT) @(negedge clk);
    total++; if (timeout_seen != to0) begin bad++; $display("FAIL resp_done_no_timeout: got %0d pulses expected 0", timeout_seen - to0); end
  endtask

  task automatic test_timeout;
    logic [47:0] bits; logic [2:0] fo; int nb, dk, csb, pb, tb, tk, to0;
    run_frame(ACMD41, 32'h40000000, -1, 0, bits, nb, dk, fo, csb, pb, tb);
    to0 = timeout_seen;
    tk = -1;
    for (int k = 1; k <= TO_LAT + 20; k++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin tk = k; break; end
    end
    total++; if (tk != TO_LAT) begin bad++; $display("FAIL timeout_latency: got %0d expected %0d", tk, TO_LAT); end
    total++; if (sd_cs_n !== 1'b1 || resp_en !== 1'b0 || busy !== 1'b0 || sd_sclk !== 1'b0)
      begin bad++; $display("FAIL timeout_idle_outputs: got cs/resp_en/busy/sclk=%b%b%b%b expected 1000", sd_cs_n, resp_en, busy, sd_sclk); end
    @(negedge clk);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_one_cycle: got %b expected 0", timeout); end
    total++; if (timeout_seen != to0 + 1) begin bad++; $display("FAIL timeout_pulse_count: got %0d expected 1", timeout_seen - to0); end
  endtask

  task automatic test_ignore_start;
    logic [47:0] bits; logic [2:0] fo; int nb, dk, csb, pb, tb;
    run_frame(CMD0, 32'h0, 40, 0, bits, nb, dk, fo, csb, pb, tb);
    total++; if (bits !== 48'h400000000095) begin bad++; $display("FAIL ignore_start_frame: got %012h expected 400000000095", bits); end
    total++; if (dk != DONE_LAT) begin bad++; $display("FAIL ignore_start_latency: got %0d expected %0d", dk, DONE_LAT); end
    repeat (5) @(negedge clk);
    start = 1'b1; resp_done = 1'b1; cmd_index = CMD8;
    @(negedge clk);
    start = 1'b0; resp_done = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL return_cycle_busy: got %b expected 0", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || sd_cs_n !== 1'b1) begin bad++; $display("FAIL return_start_ignored: got busy/cs_n=%b%b expected 01", busy, sd_cs_n); end
  endtask

  task automatic test_reset_mid;
    logic [47:0] bits; logic [2:0] fo; int nb, dk, csb, pb, tb;
    run_frame(CMD0, 32'h0, -1, 20, bits, nb, dk, fo, csb, pb, tb);
    rst = 1'b1;
    #1;
    total++; if (sd_cs_n !== 1'b1 || sd_mosi !== 1'b1 || sd_sclk !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL mid_reset_outputs: got cs/mosi/sclk/busy=%b%b%b%b expected 1100", sd_cs_n, sd_mosi, sd_sclk, busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(CMD0, 32'h0, -1, 0, bits, nb, dk, fo, csb, pb, tb);
    total++; if (bits !== 48'h400000000095) begin bad++; $display("FAIL after_reset_frame: got %012h expected 400000000095", bits); end
    total++; if (dk != DONE_LAT) begin bad++; $display("FAIL after_reset_latency: got %0d expected %0d", dk, DONE_LAT); end
    end_resp(2);
  endtask

  task automatic test_collision;
    logic [47:0] bits; logic [2:0] fo; int nb, dk, csb, pb, tb, to0;
    run_frame(CMD17, 32'h00001000, -1, 0, bits, nb, dk, fo, csb, pb, tb);
    total++; if (bits !== ref_frame(CMD17, 32'h00001000)) begin bad++; $display("FAIL cmd17_frame: got %012h expected %012h", bits, ref_frame(CMD17, 32'h00001000)); end
    to0 = timeout_seen;
    repeat (TO_LAT - 1) @(negedge clk);
    resp_done = 1'b1;
    @(negedge clk);
    resp_done = 1'b0;
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL collision_timeout: got %b expected 0", timeout); end
    total++; if (busy !== 1'b0 || resp_en !== 1'b0 || sd_cs_n !== 1'b1) begin bad++; $display("FAIL collision_idle: got busy/resp_en/cs_n=%b%b%b expected 001", busy, resp_en, sd_cs_n); end
    repeat (3) @(negedge clk);
    total++; if (timeout_seen != to0) begin bad++; $display("FAIL collision_no_pulse: got %0d pulses expected 0", timeout_seen - to0); end
  endtask

  initial begin
    test_reset;
    test_cmd0;
    test_cmd8;
    test_random;
    test_resp_done;
    test_timeout;
    test_ignore_start;
    test_reset_mid;
    test_collision;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
